imem_fetch_port: RTL

//  Parametrised, writable instruction memory with a registered fetch port and valid/ready handshake.

---
 rtl/imem_pkg.sv | 13 +
 rtl/imem_ram_1r1w.sv | 42 ++++
 rtl/imem_fetch_port.sv | 94 +++++++++
 3 files changed

// File: rtl/imem_pkg.sv
// Shared defaults and address helper for the instruction-memory fetch port.
package imem_pkg;

   localparam int          DATA_W_DEF    = 32;
   localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0000;

   // Word index of a fetch address. In byte mode the low two bits select a byte
   // inside the word and are dropped here; the caller checks their alignment.
   function automatic logic [31:0] word_idx(input logic [31:0] pc, input logic byte_addr);
      return byte_addr ? {2'b00, pc[31:2]} : pc;
   endfunction

endpackage

// File: rtl/imem_ram_1r1w.sv
// DEPTH x DATA_W array: one synchronous write port and one synchronous,
// read-before-write read port whose output register holds when not read.
module imem_ram_1r1w #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 32,
   parameter int AW     = 5
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              we,
   input  logic [AW-1:0]     waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic              re,
   input  logic [AW-1:0]     raddr,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] rdata_q;

   // NOTE: the array has no reset on purpose. Clearing it would need a
   // multi-cycle sequence or flop-based storage, and loaded program contents
   // must survive a reset anyway.
   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[waddr] <= wdata;
      end
   end

   // NOTE: non-blocking assignments make the read sample the array as it was
   // before this edge's write, which is what gives read-before-write.
   always_ff @(posedge clk) begin
      if (reset) begin
         rdata_q <= '0;
      end else if (re) begin
         rdata_q <= mem_q[raddr];
      end
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/imem_fetch_port.sv
// Writable instruction memory with a one-cycle registered fetch port,
// valid/ready handshake, and flagged out-of-range or misaligned fetches.
module imem_fetch_port
   import imem_pkg::*;
#(
   parameter int                DATA_W    = DATA_W_DEF,
   parameter int                DEPTH     = 32,
   parameter int                PC_W      = 8,
   parameter int                BYTE_ADDR = 0,
   parameter logic [DATA_W-1:0] NOP_INSTR = DATA_W'(NOP_INSTR_DEF)
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     ld_en,
   input  logic [$clog2(DEPTH)-1:0] ld_addr,
   input  logic [DATA_W-1:0]        ld_data,
   input  logic                     req_valid,
   output logic                     req_ready,
   input  logic [PC_W-1:0]          req_pc,
   output logic                     rsp_valid,
   input  logic                     rsp_ready,
   output logic [DATA_W-1:0]        rsp_instr,
   output logic [PC_W-1:0]          rsp_pc,
   output logic                     rsp_err
);

   localparam int AW = $clog2(DEPTH);

   logic            rsp_valid_q, rsp_valid_d;
   logic [PC_W-1:0] rsp_pc_q, rsp_pc_d;
   logic            rsp_err_q, rsp_err_d;

   logic [31:0]       pc_ext;
   logic [31:0]       idx;
   logic              req_err;
   logic              accept;
   logic              ld_ok;
   logic [DATA_W-1:0] ram_rdata;

   assign pc_ext  = 32'(req_pc);
   assign idx     = word_idx(pc_ext, BYTE_ADDR != 0);
   assign req_err = (idx >= 32'(DEPTH)) || ((BYTE_ADDR != 0) && (pc_ext[1:0] != 2'b00));

   assign req_ready = !reset && (!rsp_valid_q || rsp_ready);
   assign accept    = req_valid && req_ready;
   assign ld_ok     = ld_en && (32'(ld_addr) < 32'(DEPTH));

   imem_ram_1r1w #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .AW     (AW)
   ) u_ram (
      .clk   (clk),
      .reset (reset),
      .we    (ld_ok),
      .waddr (ld_addr),
      .wdata (ld_data),
      .re    (accept && !req_err),
      .raddr (idx[AW-1:0]),
      .rdata (ram_rdata)
   );

   // A new accept overwrites the held response; otherwise a handshake retires it.
   always_comb begin
      rsp_valid_d = rsp_valid_q;
      rsp_pc_d    = rsp_pc_q;
      rsp_err_d   = rsp_err_q;
      if (accept) begin
         rsp_valid_d = 1'b1;
         rsp_pc_d    = req_pc;
         rsp_err_d   = req_err;
      end else if (rsp_ready) begin
         rsp_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rsp_valid_q <= 1'b0;
         rsp_pc_q    <= '0;
         rsp_err_q   <= 1'b0;
      end else begin
         rsp_valid_q <= rsp_valid_d;
         rsp_pc_q    <= rsp_pc_d;
         rsp_err_q   <= rsp_err_d;
      end
   end

   assign rsp_valid = rsp_valid_q;
   assign rsp_pc    = rsp_pc_q;
   assign rsp_err   = rsp_err_q;
   assign rsp_instr = rsp_err_q ? NOP_INSTR : ram_rdata;

endmodule
